// File: rtl/dcache_ctrl_pkg.sv
// rtl/dcache_ctrl_pkg.sv - shared types, widths and byte-merge helper for the data cache
//
// Purpose: controller state encoding, line/offset/strobe widths and the
//          wstrb -> 64-bit byte mask function used by the controller and the
//          data array.
// Ports:   none (package).
package dcache_ctrl_pkg;

  localparam int LINE_W = 64;
  localparam int OFF_W  = 3;
  localparam int STRB_W = LINE_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    WB_REQ  = 3'd2,
    WB_WAIT = 3'd3,
    RF_REQ  = 3'd4,
    RF_WAIT = 3'd5,
    RESP    = 3'd6
  } state_t;

  // Expand each strobe bit into a full byte lane of the returned mask.
  function automatic logic [LINE_W-1:0] strb_mask(input logic [STRB_W-1:0] strb);
    logic [LINE_W-1:0] m;
    for (int b = 0; b < STRB_W; b++) begin
      m[b*8 +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dcache_data_array.sv
// rtl/dcache_data_array.sv - 2^INDEX_W x 64-bit line storage with byte-strobed write
//
// Purpose: holds the cached data lines; contents are not reset.
// Ports:   i_clk    clock
//          i_we     write enable
//          i_idx    line index for both read and write
//          i_wdata  write data
//          i_wstrb  byte enables for the write
//          o_rdata  combinational read of line i_idx
module dcache_data_array
  import dcache_ctrl_pkg::*;
#(
  parameter int INDEX_W = 4
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [INDEX_W-1:0] i_idx,
  input  logic [LINE_W-1:0]  i_wdata,
  input  logic [STRB_W-1:0]  i_wstrb,
  output logic [LINE_W-1:0]  o_rdata
);

  logic [LINE_W-1:0] r_mem [1 << INDEX_W];
  logic [LINE_W-1:0] w_mask;

  assign w_mask  = strb_mask(i_wstrb);
  assign o_rdata = r_mem[i_idx];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_idx] <= (r_mem[i_idx] & ~w_mask) | (i_wdata & w_mask);
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
//
// Purpose: owns tag/valid/dirty state, sequences hit, writeback and refill,
//          one outstanding request per side.
// Ports:   i_clk, i_rst (async active-high)
//          CPU side: i_cpu_req_valid/o_cpu_req_ready, i_cpu_req_we, i_cpu_req_addr,
//                    i_cpu_req_wdata, i_cpu_req_wstrb, o_cpu_resp_valid, o_cpu_resp_rdata
//          Mem side: o_mem_req_valid/i_mem_req_ready, o_mem_req_we, o_mem_req_addr,
//                    o_mem_req_wdata, i_mem_resp_valid, i_mem_resp_rdata
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req_valid,
  output logic              o_cpu_req_ready,
  input  logic              i_cpu_req_we,
  input  logic [ADDR_W-1:0] i_cpu_req_addr,
  input  logic [LINE_W-1:0] i_cpu_req_wdata,
  input  logic [STRB_W-1:0] i_cpu_req_wstrb,
  output logic              o_cpu_resp_valid,
  output logic [LINE_W-1:0] o_cpu_resp_rdata,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic              o_mem_req_we,
  output logic [ADDR_W-1:0] o_mem_req_addr,
  output logic [LINE_W-1:0] o_mem_req_wdata,
  input  logic              i_mem_resp_valid,
  input  logic [LINE_W-1:0] i_mem_resp_rdata
);

  localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;
  localparam int NLINES = 1 << INDEX_W;

  state_t                r_state, w_state_nxt;
  logic                  r_we;
  logic [ADDR_W-1:OFF_W] r_addr;
  logic [LINE_W-1:0]     r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [LINE_W-1:0]     r_rdata;
  logic [NLINES-1:0]     r_valid;
  logic [NLINES-1:0]     r_dirty;
  logic [TAG_W-1:0]      r_tag [NLINES];

  logic               w_accept, w_hit, w_wb_done, w_rf_done, w_arr_we;
  logic               w_unused_offset;
  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_req_tag, w_old_tag;
  logic [LINE_W-1:0]  w_line, w_store_mask, w_arr_wdata;
  logic [STRB_W-1:0]  w_arr_wstrb;

  assign w_idx            = r_addr[INDEX_W+OFF_W-1:OFF_W];
  assign w_req_tag        = r_addr[ADDR_W-1:INDEX_W+OFF_W];
  assign w_old_tag        = r_tag[w_idx];
  assign w_hit            = r_valid[w_idx] && (w_old_tag == w_req_tag);
  assign o_cpu_req_ready  = (r_state == IDLE) && !i_rst;
  assign w_accept         = i_cpu_req_valid && o_cpu_req_ready;
  assign w_wb_done        = (r_state == WB_WAIT) && i_mem_resp_valid;
  assign w_rf_done        = (r_state == RF_WAIT) && i_mem_resp_valid;
  assign w_store_mask     = r_we ? strb_mask(r_wstrb) : '0;
  assign o_cpu_resp_rdata = r_rdata;
  // Byte offset within the line is not needed by a one-word line.
  assign w_unused_offset  = ^i_cpu_req_addr[OFF_W-1:0];

  dcache_data_array #(.INDEX_W(INDEX_W)) u_data (
    .i_clk   (i_clk),
    .i_we    (w_arr_we),
    .i_idx   (w_idx),
    .i_wdata (w_arr_wdata),
    .i_wstrb (w_arr_wstrb),
    .o_rdata (w_line)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= i_cpu_req_we;
        r_addr  <= i_cpu_req_addr[ADDR_W-1:OFF_W];
        r_wdata <= i_cpu_req_wdata;
        r_wstrb <= i_cpu_req_wstrb;
      end
      if ((r_state == LOOKUP) && w_hit) begin
        r_rdata <= r_we ? '0 : w_line;
        if (r_we) r_dirty[w_idx] <= 1'b1;
      end
      if (w_wb_done) r_dirty[w_idx] <= 1'b0;
      // A store miss allocates and merges in the same cycle, so the line is dirty at once.
      if (w_rf_done) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= r_we;
        r_rdata        <= r_we ? '0 : i_mem_resp_rdata;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_rf_done) r_tag[w_idx] <= w_req_tag;
  end

  always_comb begin
    w_state_nxt      = r_state;
    o_cpu_resp_valid = 1'b0;
    o_mem_req_valid  = 1'b0;
    o_mem_req_we     = 1'b0;
    o_mem_req_addr   = '0;
    o_mem_req_wdata  = '0;
    w_arr_we         = 1'b0;
    w_arr_wdata      = r_wdata;
    w_arr_wstrb      = r_wstrb;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (w_hit) begin
          w_arr_we    = r_we;
          w_state_nxt = RESP;
        end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
          w_state_nxt = WB_REQ;
        end else begin
          w_state_nxt = RF_REQ;
        end
      end
      WB_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_we    = 1'b1;
        o_mem_req_addr  = {w_old_tag, w_idx, {OFF_W{1'b0}}};
        o_mem_req_wdata = w_line;
        if (i_mem_req_ready) w_state_nxt = WB_WAIT;
      end
      WB_WAIT: begin
        if (i_mem_resp_valid) w_state_nxt = RF_REQ;
      end
      RF_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_addr  = {w_req_tag, w_idx, {OFF_W{1'b0}}};
        if (i_mem_req_ready) w_state_nxt = RF_WAIT;
      end
      RF_WAIT: begin
        if (i_mem_resp_valid) begin
          // Install refill data with any pending store bytes merged over it.
          w_arr_we    = 1'b1;
          w_arr_wdata = (i_mem_resp_rdata & ~w_store_mask) | (r_wdata & w_store_mask);
          w_arr_wstrb = '1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        o_cpu_resp_valid = 1'b1;
        w_state_nxt      = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl
module tb_dcache_ctrl;

  localparam int ADDR_W  = 32;
  localparam int INDEX_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [31:0] cpu_req_addr;
  logic [63:0] cpu_req_wdata;
  logic [7:0]  cpu_req_wstrb;
  logic        cpu_resp_valid;
  logic [63:0] cpu_resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  always #5 clk = ~clk;

  dcache_ctrl #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_cpu_req_valid  (cpu_req_valid),
    .o_cpu_req_ready  (cpu_req_ready),
    .i_cpu_req_we     (cpu_req_we),
    .i_cpu_req_addr   (cpu_req_addr),
    .i_cpu_req_wdata  (cpu_req_wdata),
    .i_cpu_req_wstrb  (cpu_req_wstrb),
    .o_cpu_resp_valid (cpu_resp_valid),
    .o_cpu_resp_rdata (cpu_resp_rdata),
    .o_mem_req_valid  (mem_req_valid),
    .i_mem_req_ready  (mem_req_ready),
    .o_mem_req_we     (mem_req_we),
    .o_mem_req_addr   (mem_req_addr),
    .o_mem_req_wdata  (mem_req_wdata),
    .i_mem_resp_valid (mem_resp_valid),
    .i_mem_resp_rdata (mem_resp_rdata)
  );

  typedef struct { logic [63:0] rdata; bit hit; int acc_cyc; } resp_t;
  typedef struct { logic we; logic [31:0] addr; logic [63:0] wdata; } mreq_t;

  resp_t exp_resp_q[$];
  mreq_t exp_mem_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    last_refill_cyc = 0;

  resp_t       mon_r;
  mreq_t       mon_m;
  logic        p_stall = 1'b0;
  logic        p_we;
  logic [31:0] p_addr;
  logic [63:0] p_wdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event absent, expected it", name);
  endtask

  // Monitor: samples one time unit after the falling edge, i.e. what the DUT sees at the next rise.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        p_stall = 1'b0;
      end else begin
        if (mem_req_valid) check("ready_low_during_mem", 64'(cpu_req_ready), 64'd0);
        if (p_stall) begin
          check("stall_valid", 64'(mem_req_valid), 64'd1);
          check("stall_we", 64'(mem_req_we), 64'(p_we));
          check("stall_addr", 64'(mem_req_addr), 64'(p_addr));
          check("stall_wdata", mem_req_wdata, p_wdata);
        end
        p_stall = mem_req_valid && !mem_req_ready;
        p_we    = mem_req_we;
        p_addr  = mem_req_addr;
        p_wdata = mem_req_wdata;
        if (mem_req_valid && mem_req_ready) begin
          if (exp_mem_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_mem_req: got addr %h, expected none", mem_req_addr);
          end else begin
            mon_m = exp_mem_q.pop_front();
            check("mem_we", 64'(mem_req_we), 64'(mon_m.we));
            check("mem_addr", 64'(mem_req_addr), 64'(mon_m.addr));
            if (mon_m.we) check("mem_wdata", mem_req_wdata, mon_m.wdata);
          end
        end
        if (cpu_resp_valid) begin
          if (exp_resp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_resp: got rdata %h, expected none", cpu_resp_rdata);
          end else begin
            mon_r = exp_resp_q.pop_front();
            check("resp_rdata", cpu_resp_rdata, mon_r.rdata);
            if (mon_r.hit) check("hit_latency", 64'(cyc), 64'(mon_r.acc_cyc + 2));
            else           check("miss_latency", 64'(cyc), 64'(last_refill_cyc + 1));
          end
        end
      end
    end
  end

  task automatic cpu_req(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wstrb, input logic [63:0] exp_rdata,
                         input bit hit, input bit expect_resp);
    resp_t e;
    int n = 0;
    while (!cpu_req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_req_ready) begin
      fail_now("cpu_req_ready_timeout");
      return;
    end
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
    cpu_req_wstrb = wstrb;
    if (expect_resp) begin
      e.rdata   = exp_rdata;
      e.hit     = hit;
      e.acc_cyc = cyc;
      exp_resp_q.push_back(e);
    end
    @(negedge clk);
    cpu_req_valid = 1'b0;
  endtask

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [63:0] wdata);
    mreq_t m;
    m.we    = we;
    m.addr  = addr;
    m.wdata = wdata;
    exp_mem_q.push_back(m);
  endtask

  task automatic mem_serve(input int stall, input logic [63:0] rdata, input bit respond);
    logic was_we;
    int n = 0;
    while (!mem_req_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req_valid) begin
      fail_now("mem_req_timeout");
      return;
    end
    repeat (stall) @(negedge clk);
    mem_req_ready = 1'b1;
    was_we = mem_req_we;
    @(negedge clk);
    mem_req_ready = 1'b0;
    if (!respond) return;
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    if (!was_we) last_refill_cyc = cyc;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_resp_q.size() != 0 || exp_mem_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_resp_q.size() + exp_mem_q.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_we = 1'b0;
    cpu_req_addr = '0;
    cpu_req_wdata = '0;
    cpu_req_wstrb = '0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_cpu_req_ready", 64'(cpu_req_ready), 64'd0);
    check("rst_resp_valid", 64'(cpu_resp_valid), 64'd0);
    check("rst_resp_rdata", cpu_resp_rdata, 64'd0);
    check("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    check("rst_mem_we", 64'(mem_req_we), 64'd0);
    check("rst_mem_addr", 64'(mem_req_addr), 64'd0);
    check("rst_mem_wdata", mem_req_wdata, 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(cpu_req_ready), 64'd1);
    @(negedge clk);

    // Cold load miss then hit.
    push_mem(1'b0, 32'h1000, 64'd0);
    cpu_req(1'b0, 32'h1000, 64'd0, 8'h00, 64'hDEADBEEF_00000001, 1'b0, 1'b1);
    mem_serve(0, 64'hDEADBEEF_00000001, 1'b1);
    drain("drain_cold_miss");
    cpu_req(1'b0, 32'h1000, 64'd0, 8'h00, 64'hDEADBEEF_00000001, 1'b1, 1'b1);
    drain("drain_load_hit");

    // Store hit on low four bytes, then load sees merged line.
    cpu_req(1'b1, 32'h1000, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, 64'd0, 1'b1, 1'b1);
    drain("drain_store_hit");
    cpu_req(1'b0, 32'h1000, 64'd0, 8'h00, 64'hDEADBEEF_FFFFFFFF, 1'b1, 1'b1);
    drain("drain_load_merged");

    // Dirty conflict miss with a 5-cycle stalled writeback.
    push_mem(1'b1, 32'h1000, 64'hDEADBEEF_FFFFFFFF);
    push_mem(1'b0, 32'h1080, 64'd0);
    cpu_req(1'b0, 32'h1080, 64'd0, 8'h00, 64'h11112222_33334444, 1'b0, 1'b1);
    mem_serve(5, 64'd0, 1'b1);
    mem_serve(0, 64'h11112222_33334444, 1'b1);
    drain("drain_evict");

    // Back-to-back hits.
    cpu_req(1'b0, 32'h1080, 64'd0, 8'h00, 64'h11112222_33334444, 1'b1, 1'b1);
    cpu_req(1'b0, 32'h1088 - 32'h8, 64'd0, 8'h00, 64'h11112222_33334444, 1'b1, 1'b1);
    drain("drain_b2b");

    // Store miss with single-byte strobe, then evict it.
    push_mem(1'b0, 32'h2008, 64'd0);
    cpu_req(1'b1, 32'h2008, 64'h00000000_000000AA, 8'h01, 64'd0, 1'b0, 1'b1);
    mem_serve(0, 64'h01234567_89ABCDEF, 1'b1);
    drain("drain_store_miss");
    push_mem(1'b1, 32'h2008, 64'h01234567_89ABCDAA);
    push_mem(1'b0, 32'h2088, 64'd0);
    cpu_req(1'b0, 32'h2088, 64'd0, 8'h00, 64'hCAFEF00D_12345678, 1'b0, 1'b1);
    mem_serve(0, 64'd0, 1'b1);
    mem_serve(0, 64'hCAFEF00D_12345678, 1'b1);
    drain("drain_store_evict");

    // Spurious memory response while idle.
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hBADBADBA_DBADBAD0;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    @(negedge clk);
    check("spurious_ready", 64'(cpu_req_ready), 64'd1);
    cpu_req(1'b0, 32'h2088, 64'd0, 8'h00, 64'hCAFEF00D_12345678, 1'b1, 1'b1);
    drain("drain_after_spurious");

    // Reset while waiting for refill data.
    push_mem(1'b0, 32'h3000, 64'd0);
    cpu_req(1'b0, 32'h3000, 64'd0, 8'h00, 64'd0, 1'b0, 1'b0);
    mem_serve(0, 64'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(cpu_req_ready), 64'd0);
    check("mid_rst_mem_valid", 64'(mem_req_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("after_rst_ready", 64'(cpu_req_ready), 64'd1);
    @(negedge clk);
    push_mem(1'b0, 32'h1080, 64'd0);
    cpu_req(1'b0, 32'h1080, 64'd0, 8'h00, 64'h55555555_AAAAAAAA, 1'b0, 1'b1);
    mem_serve(0, 64'h55555555_AAAAAAAA, 1'b1);
    drain("drain_post_reset_miss");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
